mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
// - Memory-stage load/store unit of the RV32I pipeline; drives the data bus, produces ReadDataM and the MEM/WB enable.
// - Converts each MEM-stage load/store into one valid/ready bus request plus one response.
// - Aligns and sign/zero-extends load data.
// - Stalls the pipeline (StallM) until the access completes.
// PARAMETERS
// - TIMEOUT_CYCLES   0   max WAIT cycles before fault; 0 = no timeout
// - CNT_W            8   timeout counter width; TIMEOUT_CYCLES < 2**CNT_W
// PORTS
// - clk            in   1   clock
// - rst            in   1   reset, asynchronous, active-low
// - MemReqM        in   1   MEM-stage instruction is a load or store
// - MemWriteM      in   1   1 = store, 0 = load
// - Funct3M        in   3   access size/sign (RV32I funct3)
// - AddrM          in   32  effective address (ALUResultM)
// - WriteDataM     in   32  store data, low-aligned
// - bus_req_valid  out  1   request valid
// - bus_req_ready  in   1   request accepted
// - bus_addr       out  32  word-aligned address {AddrM[31:2],2'b00}
// - bus_we         out  1   write enable
// - bus_wstrb      out  4   byte strobes
// - bus_wdata      out  32  lane-replicated store data
// - bus_rsp_valid  in   1   response valid (loads and stores)
// - bus_rdata      in   32  read word
// - bus_err        in   1   error, qualified by bus_rsp_valid
// - ReadDataM      out  32  aligned/extended load result
// - StallM         out  1   1 = hold IF..MEM; MEM/WB EN = ~StallM
// - MisalignM      out  1   1-cycle pulse: misaligned access, no bus traffic
// - FaultM         out  1   1-cycle pulse: bus_err or timeout
// BEHAVIOUR
// - Reset: state IDLE. bus_req_valid=0, bus_we=0, bus_wstrb=0, bus_addr=0, bus_wdata=0, ReadDataM=0, MisalignM=0, FaultM=0, counter=0.
// - Reset asserted mid-transaction aborts it and drops bus_req_valid at once; a late response is ignored in IDLE.
// - Alignment:
//   - byte: always aligned
//   - half: AddrM[0]=0
//   - word: AddrM[1:0]=0
//   - Funct3 011/110/111 treated as misaligned
// - FSM IDLE->REQ->WAIT->DONE->IDLE:
//   - IDLE:
//     - MemReqM & aligned: register addr/we/wstrb/wdata/funct3/off; go to REQ.
//     - MemReqM & misaligned: MisalignM=1 next cycle; stay IDLE; no stall.
//   - REQ: bus_req_valid=1. All bus_* outputs held stable until bus_req_ready. On ready, go to WAIT and clear the counter.
//   - WAIT: bus_req_valid=0. On bus_rsp_valid, capture the aligned load (or 0 for a store or on error) into ReadDataM. Set FaultM=bus_err; go to DONE.
//   - WAIT timeout: when TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 with no response, then FaultM=1, ReadDataM=0, go to DONE.
//   - DONE: StallM=0 for exactly one cycle so MEM/WB captures ReadDataM; then IDLE.
// - StallM = MemReqM & aligned & (state!=DONE). Combinational, so it is high in the request cycle.
// - Minimum access latency is 4 cycles (IDLE, REQ with ready=1, WAIT with rsp=1, DONE).
// - Strobes: SB 4'b0001<<off; SH 4'b0011<<off; SW 4'b1111. wdata: SB {4{b}}, SH {2{h}}, SW word.
// - Loads: select the byte/half at offset off.
//   - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
// - bus_rsp_valid outside WAIT is ignored.
// - A response in the same cycle as timeout expiry wins (no fault).
// STRUCTURE
// - Shared package (rv32i_pkg): funct3 load/store constants, FSM state encoding.
// - One sub-module: lsu_align (combinational) for the strobe/wdata generator and load extractor/extender.
// TESTING
// - LW 0x100: ready=1, rsp after 2 cycles with rdata=0xDEADBEEF -> ReadDataM=0xDEADBEEF, StallM high 4 cycles.
// - LB 0x103, rdata=0x80xxxxxx -> ReadDataM=0xFFFFFF80. LBU 0x103 -> ReadDataM=0x00000080.
// - SH 0x102 with data 0x1234 -> bus_wstrb=4'b1100, bus_wdata=0x12341234, bus_we=1, bus_addr=0x100.
// - LW 0x101 -> MisalignM pulse, bus_req_valid never asserted, StallM=0.
// - Request backpressure: bus_req_ready low 3 cycles -> bus_addr/bus_wdata/bus_wstrb stable throughout; single handshake.
// - TIMEOUT_CYCLES=4 with no response -> FaultM pulse 4 cycles after acceptance. rst low in WAIT -> IDLE, outputs at reset values.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the memory stage: funct3 access codes and LSU FSM states.
package rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} lsu_state_e;

  // Reserved funct3 codes (011/110/111) report as misaligned so they never reach the bus.
  function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] off);
    logic ok;
    case (funct3)
      F3_B, F3_BU: ok = 1'b1;
      F3_H, F3_HU: ok = ~off[0];
      F3_W:        ok = (off == 2'b00);
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Store strobe/lane-replication generator and load byte/half extractor with sign/zero extension.
module lsu_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [3:0]  st_strb,
  output logic [31:0] st_wdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  assign shifted = ld_word >> {ld_off, 3'b000};

  always_comb begin
    st_strb  = 4'b1111;
    st_wdata = st_data;
    case (st_funct3[1:0])
      2'b00: begin
        st_strb  = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      2'b01: begin
        st_strb  = 4'b0011 << st_off;
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_data = ld_word;
    case (ld_funct3)
      F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   ld_data = {24'h000000, shifted[7:0]};
      F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   ld_data = {16'h0000, shifted[15:0]};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one valid/ready request plus one response per access, stalling
// the pipeline until the access completes.
module mem_stage_lsu
  import rv32i_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] AddrM,
  input  logic [31:0] WriteDataM,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        FaultM
);

  lsu_state_e state_q, state_d;

  logic [31:0]      addr_q, wdata_q, rdata_q;
  logic [3:0]       wstrb_q;
  logic             we_q;
  logic [2:0]       funct3_q;
  logic [1:0]       off_q;
  logic [CNT_W-1:0] cnt_q;
  logic             misalign_q, fault_q;

  logic        aligned, timeout;
  logic [3:0]  st_strb;
  logic [31:0] st_wdata, ld_data;

  assign aligned = is_aligned(Funct3M, AddrM[1:0]);
  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  lsu_align u_align (
    .st_funct3 (Funct3M),
    .st_off    (AddrM[1:0]),
    .st_data   (WriteDataM),
    .ld_funct3 (funct3_q),
    .ld_off    (off_q),
    .ld_word   (bus_rdata),
    .st_strb   (st_strb),
    .st_wdata  (st_wdata),
    .ld_data   (ld_data)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (MemReqM && aligned) state_d = StReq;
      StReq:   if (bus_req_ready) state_d = StWait;
      StWait:  if (bus_rsp_valid || timeout) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      we_q       <= 1'b0;
      funct3_q   <= '0;
      off_q      <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      misalign_q <= (state_q == StIdle) && MemReqM && !aligned;
      // A response arriving with timeout expiry takes priority over the timeout.
      fault_q    <= (state_q == StWait) && (bus_rsp_valid ? bus_err : timeout);
      if (state_q == StIdle && MemReqM && aligned) begin
        addr_q   <= {AddrM[31:2], 2'b00};
        we_q     <= MemWriteM;
        wstrb_q  <= MemWriteM ? st_strb : 4'b0000;
        wdata_q  <= st_wdata;
        funct3_q <= Funct3M;
        off_q    <= AddrM[1:0];
      end
      if (state_q == StReq && bus_req_ready) begin
        cnt_q <= '0;
      end else if (state_q == StWait) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (state_q == StWait) begin
        if (bus_rsp_valid) begin
          rdata_q <= (we_q || bus_err) ? 32'h0 : ld_data;
        end else if (timeout) begin
          rdata_q <= 32'h0;
        end
      end
    end
  end

  assign bus_req_valid = (state_q == StReq);
  assign bus_addr      = addr_q;
  assign bus_we        = we_q;
  assign bus_wstrb     = wstrb_q;
  assign bus_wdata     = wdata_q;
  assign ReadDataM     = rdata_q;
  assign MisalignM     = misalign_q;
  assign FaultM        = fault_q;
  assign StallM        = MemReqM && aligned && (state_q != StDone);

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed vector table, randomized accesses against a
// behavioural model, and hand-written reset sequences.
module tb_mem_stage_lsu;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReqM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] AddrM, WriteDataM;
  logic        bus_req_valid, bus_req_ready;
  logic [31:0] bus_addr, bus_wdata, bus_rdata, ReadDataM;
  logic        bus_we, bus_rsp_valid, bus_err;
  logic [3:0]  bus_wstrb;
  logic        StallM, MisalignM, FaultM;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .MemReqM       (MemReqM),
    .MemWriteM     (MemWriteM),
    .Funct3M       (Funct3M),
    .AddrM         (AddrM),
    .WriteDataM    (WriteDataM),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_addr      (bus_addr),
    .bus_we        (bus_we),
    .bus_wstrb     (bus_wstrb),
    .bus_wdata     (bus_wdata),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rdata     (bus_rdata),
    .bus_err       (bus_err),
    .ReadDataM     (ReadDataM),
    .StallM        (StallM),
    .MisalignM     (MisalignM),
    .FaultM        (FaultM)
  );

  typedef struct {
    logic [2:0]  f3;
    logic        we;
    logic [31:0] addr, wd, rdata;
    logic        err;
    int          rdly;   // REQ cycles with ready low
    int          sdly;   // WAIT cycle index of the response; >= TMO means never
    logic [31:0] e_rd;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    int          e_mis, e_fault;
  } vec_t;

  typedef struct {
    logic [31:0] rd, addr, wdata;
    logic [3:0]  strb;
    logic        we;
    int          stall, mis, fault, hs, valid;
    bit          stable, done;
  } obs_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  function automatic vec_t mkv(logic [2:0] f3, logic we, logic [31:0] addr, logic [31:0] wd,
                               logic [31:0] rdata, logic err, int rdly, int sdly,
                               logic [31:0] e_rd, logic [3:0] e_strb, logic [31:0] e_wdata,
                               int e_mis, int e_fault);
    vec_t v;
    v.f3 = f3; v.we = we; v.addr = addr; v.wd = wd; v.rdata = rdata; v.err = err;
    v.rdly = rdly; v.sdly = sdly; v.e_rd = e_rd; v.e_strb = e_strb; v.e_wdata = e_wdata;
    v.e_mis = e_mis; v.e_fault = e_fault;
    return v;
  endfunction

  // Reference model, straight from the access rules.
  function automatic bit m_aligned(logic [2:0] f3, logic [31:0] a);
    case (f3)
      3'd0, 3'd4: return 1'b1;
      3'd1, 3'd5: return (a % 2) == 0;
      3'd2:       return (a % 4) == 0;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] f3, logic [31:0] a, logic [31:0] word);
    int unsigned sh = word >> (8 * (a % 4));
    int b = int'(sh % 256);
    int h = int'(sh % 65536);
    case (f3)
      3'd0:    return 32'(b >= 128 ? b - 256 : b);
      3'd4:    return 32'(b);
      3'd1:    return 32'(h >= 32768 ? h - 65536 : h);
      3'd5:    return 32'(h);
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] m_strb(logic [2:0] f3, logic [31:0] a);
    case (f3)
      3'd0:    return 4'(1 << (a % 4));
      3'd1:    return 4'(3 << (a % 4));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(logic [2:0] f3, logic [31:0] wd);
    case (f3)
      3'd0:    return (wd % 256) * 32'h0101_0101;
      3'd1:    return (wd % 65536) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic vec_t m_fill(vec_t v);
    vec_t r = v;
    r.e_mis   = m_aligned(v.f3, v.addr) ? 0 : 1;
    r.e_strb  = m_strb(v.f3, v.addr);
    r.e_wdata = m_wdata(v.f3, v.wd);
    if (v.sdly >= int'(TMO)) begin
      r.e_fault = 1;
      r.e_rd    = 32'h0;
    end else begin
      r.e_fault = v.err ? 1 : 0;
      r.e_rd    = (v.we || v.err) ? 32'h0 : m_load(v.f3, v.addr, v.rdata);
    end
    if (r.e_mis != 0) r.e_fault = 0;
    return r;
  endfunction

  // Acts as the pipeline plus a bus responder for one access, then one trailing idle cycle.
  task automatic run_access(input vec_t v, output obs_t o);
    int  req_n = 0;
    int  wait_n = 0;
    bit  accepted = 0;
    o.rd = 0; o.addr = 0; o.wdata = 0; o.strb = 0; o.we = 0;
    o.stall = 0; o.mis = 0; o.fault = 0; o.hs = 0; o.valid = 0; o.stable = 1; o.done = 0;
    @(posedge clk); #1;
    MemReqM = 1'b1; MemWriteM = v.we; Funct3M = v.f3; AddrM = v.addr; WriteDataM = v.wd;
    bus_rdata = v.rdata; bus_err = v.err;
    for (int cyc = 0; cyc < 40; cyc++) begin
      bus_req_ready = bus_req_valid && (req_n >= v.rdly);
      bus_rsp_valid = accepted && (wait_n == v.sdly);
      @(negedge clk);
      if (StallM) o.stall++;
      if (MisalignM) o.mis++;
      if (FaultM) o.fault++;
      if (bus_req_valid) begin
        if (req_n == 0) begin
          o.addr = bus_addr; o.wdata = bus_wdata; o.strb = bus_wstrb; o.we = bus_we;
        end else if (bus_addr !== o.addr || bus_wdata !== o.wdata || bus_wstrb !== o.strb ||
                     bus_we !== o.we) begin
          o.stable = 0;
        end
        req_n++;
        o.valid++;
        if (bus_req_ready) begin
          o.hs++;
          accepted = 1;
        end
      end else if (accepted) begin
        wait_n++;
      end
      if (!StallM) begin
        o.rd   = ReadDataM;
        o.done = 1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    MemReqM = 1'b0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
    @(negedge clk);
    if (MisalignM) o.mis++;
    if (FaultM) o.fault++;
  endtask

  task automatic apply(input string nm, input vec_t v);
    obs_t o;
    int   wcyc;
    run_access(v, o);
    check({nm, ".done"}, 32'(o.done), 32'd1);
    check({nm, ".mis"}, 32'(o.mis), 32'(v.e_mis));
    check({nm, ".fault"}, 32'(o.fault), 32'(v.e_fault));
    if (v.e_mis != 0) begin
      check({nm, ".stall"}, 32'(o.stall), 32'd0);
      check({nm, ".valid"}, 32'(o.valid), 32'd0);
    end else begin
      wcyc = (v.sdly >= int'(TMO)) ? int'(TMO) : v.sdly + 1;
      check({nm, ".stall"}, 32'(o.stall), 32'(2 + v.rdly + wcyc));
      check({nm, ".valid"}, 32'(o.valid), 32'(v.rdly + 1));
      check({nm, ".hs"}, 32'(o.hs), 32'd1);
      check({nm, ".stable"}, 32'(o.stable), 32'd1);
      check({nm, ".rd"}, o.rd, v.e_rd);
      check({nm, ".addr"}, o.addr, {v.addr[31:2], 2'b00});
      check({nm, ".we"}, 32'(o.we), 32'(v.we));
      if (v.we) begin
        check({nm, ".strb"}, 32'(o.strb), 32'(v.e_strb));
        check({nm, ".wdata"}, o.wdata, v.e_wdata);
      end
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, ".valid"}, 32'(bus_req_valid), 32'd0);
    check({nm, ".we"}, 32'(bus_we), 32'd0);
    check({nm, ".strb"}, 32'(bus_wstrb), 32'd0);
    check({nm, ".addr"}, bus_addr, 32'd0);
    check({nm, ".wdata"}, bus_wdata, 32'd0);
    check({nm, ".rd"}, ReadDataM, 32'd0);
    check({nm, ".mis"}, 32'(MisalignM), 32'd0);
    check({nm, ".fault"}, 32'(FaultM), 32'd0);
  endtask

  vec_t tbl[15];

  initial begin
    rst = 1'b0; MemReqM = 0; MemWriteM = 0; Funct3M = 0; AddrM = 0; WriteDataM = 0;
    bus_req_ready = 0; bus_rsp_valid = 0; bus_rdata = 0; bus_err = 0;

    tbl[0]  = mkv(3'b010, 0, 32'h100, 0, 32'hDEADBEEF, 0, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0);
    tbl[1]  = mkv(3'b000, 0, 32'h103, 0, 32'h80123456, 0, 0, 0, 32'hFFFFFF80, 0, 0, 0, 0);
    tbl[2]  = mkv(3'b100, 0, 32'h103, 0, 32'h80123456, 0, 0, 0, 32'h00000080, 0, 0, 0, 0);
    tbl[3]  = mkv(3'b001, 1, 32'h102, 32'h1234, 0, 0, 0, 0, 0, 4'b1100, 32'h12341234, 0, 0);
    tbl[4]  = mkv(3'b010, 0, 32'h101, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[5]  = mkv(3'b010, 1, 32'h200, 32'hCAFEF00D, 0, 0, 3, 0, 0, 4'hF, 32'hCAFEF00D, 0, 0);
    tbl[6]  = mkv(3'b010, 0, 32'h300, 0, 32'h55555555, 0, 0, 99, 0, 0, 0, 0, 1);
    tbl[7]  = mkv(3'b001, 0, 32'h102, 0, 32'h80010000, 1, 0, 0, 0, 0, 0, 0, 1);
    tbl[8]  = mkv(3'b101, 0, 32'h106, 0, 32'hABCD1234, 0, 1, 0, 32'h0000ABCD, 0, 0, 0, 0);
    tbl[9]  = mkv(3'b000, 1, 32'h101, 32'hA5, 0, 0, 0, 2, 0, 4'b0010, 32'hA5A5A5A5, 0, 0);
    tbl[10] = mkv(3'b011, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[11] = mkv(3'b010, 0, 32'h400, 0, 32'h11223344, 0, 0, 3, 32'h11223344, 0, 0, 0, 0);
    tbl[12] = mkv(3'b001, 0, 32'h102, 0, 32'h80010000, 0, 0, 0, 32'hFFFF8001, 0, 0, 0, 0);
    tbl[13] = mkv(3'b000, 0, 32'h101, 0, 32'h00007F00, 0, 2, 1, 32'h0000007F, 0, 0, 0, 0);
    tbl[14] = mkv(3'b001, 1, 32'h101, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    #12;
    check_reset_outputs("rst0");
    check("rst0.stall", 32'(StallM), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 15; i++) apply($sformatf("v%0d", i), tbl[i]);

    for (int i = 0; i < 40; i++) begin
      vec_t v;
      logic [2:0] pick[7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
      v.we    = 1'($urandom_range(0, 1));
      v.f3    = v.we ? 3'($urandom_range(0, 2)) : pick[$urandom_range(0, 6)];
      v.addr  = $urandom & 32'h0000_FFFF;
      v.wd    = $urandom;
      v.rdata = $urandom;
      v.err   = ($urandom_range(0, 7) == 0);
      v.rdly  = int'($urandom_range(0, 3));
      v.sdly  = int'($urandom_range(0, 5));
      apply($sformatf("r%0d", i), m_fill(v));
    end

    // Reset while a store waits in REQ: valid must drop immediately.
    @(posedge clk); #1;
    MemReqM = 1; MemWriteM = 1; Funct3M = 3'b010; AddrM = 32'h500; WriteDataM = 32'h55;
    bus_req_ready = 0;
    @(posedge clk); #1;
    check("rq.valid", 32'(bus_req_valid), 32'd1);
    #2 rst = 1'b0;
    #1 check_reset_outputs("rq");
    MemReqM = 0;
    @(posedge clk); #1;
    rst = 1'b1;

    // Reset while a load waits in WAIT, then a late response in IDLE must be ignored.
    @(posedge clk); #1;
    MemReqM = 1; MemWriteM = 0; Funct3M = 3'b010; AddrM = 32'h600; bus_req_ready = 1;
    @(posedge clk); #1;
    check("rw.req", 32'(bus_req_valid), 32'd1);
    @(posedge clk); #1;
    bus_req_ready = 0;
    check("rw.wait", 32'(bus_req_valid), 32'd0);
    check("rw.stall", 32'(StallM), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1 check_reset_outputs("rw");
    MemReqM = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    bus_rsp_valid = 1; bus_rdata = 32'hFFFFFFFF; bus_err = 1;
    @(posedge clk); #1;
    bus_rsp_valid = 0; bus_err = 0;
    @(negedge clk);
    check("late.rd", ReadDataM, 32'd0);
    check("late.fault", 32'(FaultM), 32'd0);
    check("late.valid", 32'(bus_req_valid), 32'd0);
    check("late.stall", 32'(StallM), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
